// File: rtl/sysram_dword_packer_pkg.sv
// ---------------------------------------------------------------------------
// sysram_dword_packer_pkg
// Shared definitions for the byte-to-dword packer: packer FSM state encoding,
// lane geometry and the word width used on the system RAM write port.
// ---------------------------------------------------------------------------
package sysram_dword_packer_pkg;

  localparam int LANE_W         = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Highest lane of a word; a write to it closes the word.
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  // ST_IDLE  : nothing held
  // ST_ACCUM : partial word held in the hold register
  // ST_EMIT2 : hold register carries a queued word that is written next edge
  // ST_DRAIN : flush write is on the bus; done follows
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT2 = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sysram_lane_merge.sv
// ---------------------------------------------------------------------------
// sysram_lane_merge
// Combinational merge of one data byte into its lane of a 32-bit word and
// accumulation of the matching byte enable.
//   i_fresh    : 1 = start a new word (other lanes read 0, be cleared)
//   i_acc_data : word accumulated so far
//   i_acc_be   : byte enables accumulated so far
//   i_lane     : target lane of the byte
//   i_byte     : data byte
//   o_data     : merged word (target lane overwritten, last byte wins)
//   o_be       : merged byte enables
// ---------------------------------------------------------------------------
module sysram_lane_merge
  import sysram_dword_packer_pkg::*;
(
  input  logic                      i_fresh,
  input  logic [WORD_W-1:0]         i_acc_data,
  input  logic [BYTES_PER_WORD-1:0] i_acc_be,
  input  logic [LANE_W-1:0]         i_lane,
  input  logic [7:0]                i_byte,
  output logic [WORD_W-1:0]         o_data,
  output logic [BYTES_PER_WORD-1:0] o_be
);

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic w_sel;
      assign w_sel = (i_lane == LANE_W'(gi));
      assign o_data[8*gi +: 8] = w_sel   ? i_byte :
                                 i_fresh ? 8'h00  : i_acc_data[8*gi +: 8];
      assign o_be[gi] = w_sel | (~i_fresh & i_acc_be[gi]);
    end
  endgenerate

endmodule

// File: rtl/sysram_dword_packer.sv
// ---------------------------------------------------------------------------
// sysram_dword_packer
// Packs the host-link byte-write stream into 32-bit little-endian words with
// byte enables for the system RAM write port, counts emitted words and flags
// when a host write transaction has been fully drained.
//   clk_25     : system clock
//   rst        : asynchronous active-high reset
//   byte_addr  : byte address of the current byte (lane = [1:0])
//   rx_byte    : data byte, valid with wr_byte
//   wr_byte    : byte write strobe
//   wr_cmplt   : host transaction finished, flush any held word
//   host_break : abort, discard held/queued data
//   dword_res  : clear the emitted-word counter
//   ram_wr     : one-cycle word write strobe
//   ram_addr   : word address (valid with ram_wr)
//   ram_data   : packed word (valid with ram_wr)
//   ram_be     : byte enables (valid with ram_wr)
//   dword_cnt  : words emitted since last dword_res (wraps)
//   pending    : a partial or queued word is held
//   done       : one-cycle pulse after the flush has been written
// ---------------------------------------------------------------------------
module sysram_dword_packer
  import sysram_dword_packer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic                      clk_25,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         byte_addr,
  input  logic [7:0]                rx_byte,
  input  logic                      wr_byte,
  input  logic                      wr_cmplt,
  input  logic                      host_break,
  input  logic                      dword_res,
  output logic                      ram_wr,
  output logic [ADDR_W-3:0]         ram_addr,
  output logic [WORD_W-1:0]         ram_data,
  output logic [BYTES_PER_WORD-1:0] ram_be,
  output logic [CNT_W-1:0]          dword_cnt,
  output logic                      pending,
  output logic                      done
);

  localparam int WIDX_W = ADDR_W - LANE_W;

  state_t                      r_state;
  state_t                      w_state_next;

  // Hold register: the partial word in ACCUM, the queued word in EMIT2.
  logic [WORD_W-1:0]           r_acc_data;
  logic [BYTES_PER_WORD-1:0]   r_acc_be;
  logic [WIDX_W-1:0]           r_acc_widx;
  logic                        r_flush;   // queued word was closed by wr_cmplt

  logic                        r_ram_wr;
  logic [WIDX_W-1:0]           r_ram_addr;
  logic [WORD_W-1:0]           r_ram_data;
  logic [BYTES_PER_WORD-1:0]   r_ram_be;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_done;

  logic [LANE_W-1:0]           w_lane;
  logic [WIDX_W-1:0]           w_widx;
  logic                        w_hit;
  logic                        w_cmplt;
  logic                        w_closes;
  logic [WORD_W-1:0]           w_mrg_data;
  logic [BYTES_PER_WORD-1:0]   w_mrg_be;

  logic                        w_emit;
  logic [WIDX_W-1:0]           w_emit_addr;
  logic [WORD_W-1:0]           w_emit_data;
  logic [BYTES_PER_WORD-1:0]   w_emit_be;
  logic [WORD_W-1:0]           w_acc_data_next;
  logic [BYTES_PER_WORD-1:0]   w_acc_be_next;
  logic [WIDX_W-1:0]           w_acc_widx_next;
  logic                        w_flush_next;
  logic                        w_done_next;

  assign w_lane = byte_addr[LANE_W-1:0];
  assign w_widx = byte_addr[ADDR_W-1:LANE_W];

  // Only a partial word in ACCUM can absorb the incoming byte; in every other
  // state the byte starts a fresh word.
  assign w_hit    = (r_state == ST_ACCUM) && (w_widx == r_acc_widx);
  // A flush request captured alongside a queued word is still owed in EMIT2.
  assign w_cmplt  = wr_cmplt | ((r_state == ST_EMIT2) & r_flush);
  // The incoming byte's word must go out immediately after merging.
  assign w_closes = (w_lane == LAST_LANE) | w_cmplt;

  sysram_lane_merge u_merge (
    .i_fresh    (~w_hit),
    .i_acc_data (r_acc_data),
    .i_acc_be   (r_acc_be),
    .i_lane     (w_lane),
    .i_byte     (rx_byte),
    .o_data     (w_mrg_data),
    .o_be       (w_mrg_be)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (host_break) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DRAIN: begin
          if (wr_byte) begin
            if (w_closes) w_state_next = wr_cmplt ? ST_DRAIN : ST_IDLE;
            else          w_state_next = ST_ACCUM;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_ACCUM, ST_EMIT2: begin
          if (wr_byte && w_hit) begin
            if (w_closes) w_state_next = w_cmplt ? ST_DRAIN : ST_IDLE;
            else          w_state_next = ST_ACCUM;
          end else if (wr_byte) begin
            // Held word goes out now; a closed new word is queued behind it.
            w_state_next = w_closes ? ST_EMIT2 : ST_ACCUM;
          end else if (w_cmplt) begin
            w_state_next = ST_DRAIN;
          end else if (r_state == ST_EMIT2) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_ACCUM;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_emit          = 1'b0;
    w_emit_addr     = '0;
    w_emit_data     = '0;
    w_emit_be       = '0;
    w_acc_data_next = r_acc_data;
    w_acc_be_next   = r_acc_be;
    w_acc_widx_next = r_acc_widx;
    w_flush_next    = 1'b0;
    w_done_next     = 1'b0;

    if (host_break) begin
      w_acc_data_next = '0;
      w_acc_be_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DRAIN: begin
          w_done_next = (r_state == ST_DRAIN) | (wr_cmplt & ~wr_byte);
          if (wr_byte) begin
            if (w_closes) begin
              w_emit          = 1'b1;
              w_emit_addr     = w_widx;
              w_emit_data     = w_mrg_data;
              w_emit_be       = w_mrg_be;
              w_acc_data_next = '0;
              w_acc_be_next   = '0;
            end else begin
              w_acc_data_next = w_mrg_data;
              w_acc_be_next   = w_mrg_be;
              w_acc_widx_next = w_widx;
            end
          end
        end
        ST_ACCUM, ST_EMIT2: begin
          if (wr_byte && w_hit) begin
            if (w_closes) begin
              w_emit          = 1'b1;
              w_emit_addr     = w_widx;
              w_emit_data     = w_mrg_data;
              w_emit_be       = w_mrg_be;
              w_acc_data_next = '0;
              w_acc_be_next   = '0;
            end else begin
              w_acc_data_next = w_mrg_data;
              w_acc_be_next   = w_mrg_be;
            end
          end else begin
            if ((r_state == ST_EMIT2) || wr_byte || w_cmplt) begin
              w_emit          = 1'b1;
              w_emit_addr     = r_acc_widx;
              w_emit_data     = r_acc_data;
              w_emit_be       = r_acc_be;
              w_acc_data_next = '0;
              w_acc_be_next   = '0;
            end
            if (wr_byte) begin
              w_acc_data_next = w_mrg_data;
              w_acc_be_next   = w_mrg_be;
              w_acc_widx_next = w_widx;
              w_flush_next    = w_cmplt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath, write port and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_acc_data <= '0;
      r_acc_be   <= '0;
      r_acc_widx <= '0;
      r_flush    <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_be   <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_acc_data <= w_acc_data_next;
      r_acc_be   <= w_acc_be_next;
      r_acc_widx <= w_acc_widx_next;
      r_flush    <= w_flush_next;
      r_ram_wr   <= w_emit;
      r_ram_addr <= w_emit_addr;
      r_ram_data <= w_emit_data;
      r_ram_be   <= w_emit_be;
      r_done     <= w_done_next;
      // Counts the write visible on the port this cycle; a clear in the same
      // cycle still accounts for that write.
      if (dword_res) r_cnt <= r_ram_wr ? CNT_W'(1) : '0;
      else if (r_ram_wr) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ram_wr    = r_ram_wr;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_be    = r_ram_be;
  assign dword_cnt = r_cnt;
  assign done      = r_done;
  assign pending   = (r_state == ST_ACCUM) || (r_state == ST_EMIT2);

endmodule
